nibble_add_sequencer: RTL and testbench
=======================================

NIBBLE_ADD_SEQUENCER -- requirements
Module: nibble_add_sequencer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand (operand width W = 4*NIBBLES).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition; sampled on the clk edge.
REQ-005 SHALL have port op_a, input, W bits: first operand, unsigned.
REQ-006 SHALL have port op_b, input, W bits: second operand, unsigned.
REQ-007 SHALL have port cin, input, 1 bit: carry into nibble 0.
REQ-008 SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when result is complete.
REQ-010 SHALL have port result, output, W bits: registered sum.
REQ-011 SHALL have port cout, output, 1 bit: registered carry out of the most significant nibble.
REQ-012 SHALL have port zero, output, 1 bit: high when result equals 0; valid whenever done is high and held until the next accepted start.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept start only when busy=0 (IDLE or DONE); a start in RUN SHALL be ignored without side effects.
REQ-015 On an accepted start edge, SHALL latch op_a, op_b and cin into internal registers, clear nibble index idx to 0, set the carry register to cin, and enter RUN.
REQ-016 In RUN, on each edge SHALL drive the 4-bit adder with op_a nibble idx, op_b nibble idx and the carry register; write the adder sum into result nibble idx; load the adder carry into the carry register; and increment idx.
REQ-017 When idx = NIBBLES-1 in RUN, the edge SHALL also load cout from the adder carry and transition to DONE.
REQ-018 Latency SHALL be exactly NIBBLES+1 edges from the start edge to done high; NIBBLES=4 gives done in the 5th cycle after start.
REQ-019 DONE SHALL last one cycle and then return to IDLE, unless start is high in DONE, in which case it SHALL go directly to RUN (back-to-back operation).
REQ-020 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-021 During RUN, result SHALL show partial nibbles; consumers SHALL use result only when done=1 or in IDLE.
REQ-022 result, cout and zero SHALL hold their values in IDLE until the next accepted start.
REQ-023 Carry SHALL propagate nibble to nibble with no wrap; the final carry goes only to cout. The sum is modulo 2^W.

Reset
REQ-024 rst high SHALL immediately force state=IDLE, idx=0, carry=0, result=0, cout=0, zero=1, busy=0, done=0, regardless of clk.
REQ-025 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-026 The first start SHALL be accepted on the first clk edge after rst deasserts.

Structure
REQ-027 A shared package SHALL hold NIBBLE_W=4, the default NIBBLES, and the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
REQ-028 SHALL instantiate exactly one existing 4-bit ripple adder, paralleladder (ports a, b, c, sum, cout), as the only arithmetic sub-module.
REQ-029 Nibble select and result write SHALL be indexed by idx; no W-bit adder is permitted.

Verification
REQ-030 start with op_a=16'h0001, op_b=16'h0001, cin=0 -> done in the 5th cycle; result=16'h0002, cout=0, zero=0.
REQ-031 op_a=16'hFFFF, op_b=16'h0001, cin=0 -> result=16'h0000, cout=1, zero=1.
REQ-032 op_a=16'h5A5A, op_b=16'hA5A5, cin=1 -> result=16'h0000, cout=1 (full carry chain across all nibbles).
REQ-033 start pulsed again in the 2nd RUN cycle with different operands -> ignored; the first result (16'h0B3E for 16'h0B1B+16'h0023, cin=0) completes unchanged.
REQ-034 rst asserted in the 3rd RUN cycle -> all outputs reset immediately, no done pulse; a new start with 16'h0101+16'h0101 yields 16'h0202.
REQ-035 start held high through DONE -> a second operation starts without an IDLE cycle; two done pulses occur 5 cycles apart.

Source files
------------

// File: rtl/nibble_add_sequencer_pkg.sv
// nibble_add_sequencer_pkg: nibble width, default operand size and FSM encoding
package nibble_add_sequencer_pkg;
    localparam int NIBBLE_W    = 4;
    localparam int NIBBLES_DEF = 4;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;
endpackage

// File: rtl/paralleladder.sv
// paralleladder: 4-bit ripple-carry adder
module paralleladder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] cy;
    assign cy[0] = c;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
    assign cout = cy[4];
endmodule

// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: adds two W-bit operands one nibble per cycle through a single 4-bit adder
module nibble_add_sequencer
    import nibble_add_sequencer_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLES*NIBBLE_W-1:0] op_a,
    input  logic [NIBBLES*NIBBLE_W-1:0] op_b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLES*NIBBLE_W-1:0] result,
    output logic                        cout,
    output logic                        zero
);
    localparam int W  = NIBBLES * NIBBLE_W;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
    logic            cout_q, cout_d;
    logic [IW+1:0]   base;
    logic [3:0]      add_sum;
    logic            add_co, accept, last;

    assign accept = start && (state_q != RUN);
    assign last   = (idx_q == IW'(NIBBLES - 1));
    assign base   = {idx_q, 2'b00};

    paralleladder u_add (
        .a    (a_q[base +: NIBBLE_W]),
        .b    (b_q[base +: NIBBLE_W]),
        .c    (carry_q),
        .sum  (add_sum),
        .cout (add_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        if (accept)                     state_d = RUN;
        else if (state_q == RUN)        state_d = last ? DONE : RUN;
    end

    always_comb begin
        busy   = (state_q == RUN);
        done   = (state_q == DONE);
        result = result_q;
        cout   = cout_q;
        zero   = (result_q == '0);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        if (accept) begin
            a_d     = op_a;
            b_d     = op_b;
            idx_d   = '0;
            carry_d = cin;
        end else if (state_q == RUN) begin
            result_d[base +: NIBBLE_W] = add_sum;
            carry_d = add_co;
            idx_d   = last ? '0 : idx_q + IW'(1);
            cout_d  = last ? add_co : cout_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb_nibble_add_sequencer: directed vectors with hand-computed sums, checked by immediate assertions
module tb_nibble_add_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = '0, op_b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, zero;
    logic [15:0] result;
    int          checks = 0;
    int          errors = 0;

    nibble_add_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] er, input logic ec, input logic ez);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (3) begin
            tick();
            chk({tag, "_nodone"}, 32'(done), 32'd0);
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        tick();
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        #9 rst = 1'b0;

        run_op("one_plus_one", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        run_op("ffff_plus_one", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("chain", 16'h5A5A, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b1);

        // start during RUN must not disturb the addition in flight
        op_a = 16'h0B1B; op_b = 16'h0023; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        tick();
        chk("ign_nodone", 32'(done), 32'd0);
        tick();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_result", 32'(result), 32'h0B3E);
        chk("ign_cout", 32'(cout), 32'd0);
        tick();
        chk("ign_idle", 32'(busy), 32'd0);

        op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk("abort_nodone", 32'(done), 32'd0);
        end
        run_op("after_abort", 16'h0101, 16'h0101, 1'b0, 16'h0202, 1'b0, 1'b0);

        // start held in DONE launches the next addition with no IDLE gap
        op_a = 16'h0001; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        op_a = 16'h00FF; op_b = 16'h0001; start = 1'b1;
        tick();
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_result1", 32'(result), 32'h0002);
        tick();
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_gap_done", 32'(done), 32'd0);
        repeat (3) begin
            tick();
            chk("b2b_nodone", 32'(done), 32'd0);
        end
        tick();
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_result2", 32'(result), 32'h0100);
        chk("b2b_cout2", 32'(cout), 32'd0);
        tick();
        chk("b2b_idle", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
